// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
//   Types and defaults shared by the USB RX bit-recovery slice.
//   - line_state_t   : decoded D+/D- line condition (J, K, SE0, SE1)
//   - rx_bit_state_t : bit-recovery FSM states
//   - decode_line()  : maps a synchronized (dp, dm) pair onto line_state_t
package usb_rx_pkg;

  localparam int USB_CLKS_PER_BIT = 8;
  localparam int USB_SAMPLE_POINT = 3;
  localparam int USB_STUFF_LEN    = 6;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2,
    SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SE0_ONE = 2'd2,
    DONE    = 2'd3
  } rx_bit_state_t;

  // Full-speed polarity: J drives D+ high, K drives D- high.
  function automatic line_state_t decode_line(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = J;
      2'b01:   ls = K;
      2'b00:   ls = SE0;
      default: ls = SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_bit_recover_edge.sv
// usb_edge_detect
//   Flags any change of the synchronized D+ level relative to the previous
//   clock. The previous-level register resets to 1 so that an idle J line
//   coming out of reset does not look like a transition.
//   Ports:
//     clk          system clock
//     n_rst        asynchronous active-low reset
//     d_plus_sync  synchronized D+ level
//     d_edge       combinational, high while d_plus_sync != registered copy
module usb_edge_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  output logic d_edge
);

  logic prev_dp;

  // Registered copy of D+, tracked continuously regardless of enable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_dp <= 1'b1;
    end else begin
      prev_dp <= d_plus_sync;
    end
  end

  assign d_edge = d_plus_sync ^ prev_dp;

endmodule

// File: rtl/usb_rx_bit_recover.sv
// usb_rx_bit_recover
//   Recovers bit timing from synchronized D+/D-, samples mid-bit, NRZI-decodes,
//   strips stuffed bits and detects end-of-packet.
//   Ports:
//     clk           system clock
//     n_rst         asynchronous active-low reset
//     d_plus_sync   synchronized D+ level
//     d_minus_sync  synchronized D- level
//     enable        high while the RCU is receiving a packet
//     d_edge        combinational D+ transition flag
//     bit_strobe    one-cycle pulse, bit_out valid
//     bit_out       decoded data bit (held between strobes)
//     eop           one-cycle pulse on end-of-packet
//     stuff_err     one-cycle pulse on a bit-stuff violation
//     line_err      one-cycle pulse on SE1 or an isolated SE0
module usb_rx_bit_recover
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = USB_SAMPLE_POINT,
  parameter int STUFF_LEN    = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  input  logic enable,
  output logic d_edge,
  output logic bit_strobe,
  output logic bit_out,
  output logic eop,
  output logic stuff_err,
  output logic line_err
);

  localparam int PHASE_W = $clog2(CLKS_PER_BIT);
  localparam int ONES_W  = $clog2(STUFF_LEN + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
  localparam logic [ONES_W-1:0]  ONES_MAX     = ONES_W'(STUFF_LEN);

  logic [PHASE_W-1:0] phase;
  logic [ONES_W-1:0]  ones_cnt;
  logic [ONES_W-1:0]  ones_nxt;
  logic               last_level;
  logic               last_level_nxt;
  rx_bit_state_t      state;
  rx_bit_state_t      state_nxt;

  logic        sample;
  logic        nrzi_bit;
  logic        take_data;
  line_state_t line_now;

  logic strobe_nxt;
  logic bit_out_nxt;
  logic eop_nxt;
  logic stuff_err_nxt;
  logic line_err_nxt;

  usb_edge_detect u_edge (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus_sync (d_plus_sync),
    .d_edge      (d_edge)
  );

  // Phase counter: resyncs on every D+ transition so that the sample point
  // stays mid-bit even when the transmitter clock drifts from ours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase <= '0;
    end else if (!enable || d_edge) begin
      phase <= '0;
    end else if (phase == PHASE_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end

  // An edge landing on the sample-point cycle suppresses that sample.
  assign sample   = enable && (phase == PHASE_SAMPLE) && !d_edge;
  assign line_now = decode_line(d_plus_sync, d_minus_sync);
  assign nrzi_bit = (d_plus_sync == last_level);

  // Next-state and pulse generation. A J/K sample that should be decoded
  // raises take_data; the decode/destuff step is shared by RUN and by the
  // recovery path out of SE0_ONE.
  always_comb begin
    state_nxt      = state;
    last_level_nxt = last_level;
    ones_nxt       = ones_cnt;
    strobe_nxt     = 1'b0;
    bit_out_nxt    = bit_out;
    eop_nxt        = 1'b0;
    stuff_err_nxt  = 1'b0;
    line_err_nxt   = 1'b0;
    take_data      = 1'b0;

    if (!enable) begin
      state_nxt      = IDLE;
      last_level_nxt = 1'b1;
      ones_nxt       = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = RUN;
        end
        RUN: begin
          if (sample) begin
            case (line_now)
              SE0:     state_nxt    = SE0_ONE;
              SE1:     line_err_nxt = 1'b1;
              default: take_data    = 1'b1;
            endcase
          end
        end
        SE0_ONE: begin
          if (sample) begin
            case (line_now)
              SE0: begin
                eop_nxt        = 1'b1;
                ones_nxt       = '0;
                last_level_nxt = 1'b1;
                state_nxt      = DONE;
              end
              SE1: begin
                line_err_nxt = 1'b1;
                state_nxt    = RUN;
              end
              default: begin
                line_err_nxt = 1'b1;
                take_data    = 1'b1;
                state_nxt    = RUN;
              end
            endcase
          end
        end
        default: begin
          state_nxt = DONE;
        end
      endcase
    end

    // After STUFF_LEN ones the next bit must be a stuffed 0, which is
    // consumed silently; a 1 there is a stuffing violation.
    if (take_data) begin
      last_level_nxt = d_plus_sync;
      if (ones_cnt == ONES_MAX) begin
        ones_nxt = '0;
        if (nrzi_bit) begin
          stuff_err_nxt = 1'b1;
        end
      end else begin
        strobe_nxt  = 1'b1;
        bit_out_nxt = nrzi_bit;
        ones_nxt    = nrzi_bit ? (ones_cnt + ONES_W'(1)) : '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_level <= 1'b1;
      ones_cnt   <= '0;
      bit_strobe <= 1'b0;
      bit_out    <= 1'b0;
      eop        <= 1'b0;
      stuff_err  <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_level <= last_level_nxt;
      ones_cnt   <= ones_nxt;
      bit_strobe <= strobe_nxt;
      bit_out    <= bit_out_nxt;
      eop        <= eop_nxt;
      stuff_err  <= stuff_err_nxt;
      line_err   <= line_err_nxt;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_recover.sv
// tb_usb_rx_bit_recover
//   Self-checking bench for usb_rx_bit_recover. Packets are built from data
//   bits by a transmit-side model (bit stuffing + NRZI encoding), driven onto
//   D+/D-, and the decoded strobes are compared with the original data.
module tb_usb_rx_bit_recover;

  logic clk = 1'b0;
  logic n_rst;
  logic d_plus_sync;
  logic d_minus_sync;
  logic enable;
  logic d_edge;
  logic bit_strobe;
  logic bit_out;
  logic eop;
  logic stuff_err;
  logic line_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit tx_data[$];
  bit strb_bits[$];
  int strb_cyc[$];
  int eop_cyc[$];
  int stuff_cyc[$];
  int lerr_cyc[$];

  usb_rx_bit_recover dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_sync  (d_plus_sync),
    .d_minus_sync (d_minus_sync),
    .enable       (enable),
    .d_edge       (d_edge),
    .bit_strobe   (bit_strobe),
    .bit_out      (bit_out),
    .eop          (eop),
    .stuff_err    (stuff_err),
    .line_err     (line_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (bit_strobe === 1'b1) begin
        strb_bits.push_back(bit_out);
        strb_cyc.push_back(cyc);
      end
      if (eop === 1'b1)       eop_cyc.push_back(cyc);
      if (stuff_err === 1'b1) stuff_cyc.push_back(cyc);
      if (line_err === 1'b1)  lerr_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    strb_bits.delete();
    strb_cyc.delete();
    eop_cyc.delete();
    stuff_cyc.delete();
    lerr_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_line(input logic dp, input logic dm, input int len);
    d_plus_sync  = dp;
    d_minus_sync = dm;
    step(len);
  endtask

  // Transmit model: stuff a 0 after six consecutive 1s, NRZI-encode from an
  // idle J, optionally append SE0 SE0 J, then drop enable.
  task automatic send_packet(input bit alt_period, input bit with_eop);
    bit level;
    int ones;
    bit lv[$];
    level = 1'b1;
    ones  = 0;
    foreach (tx_data[i]) begin
      if (tx_data[i] == 1'b0) level = ~level;
      lv.push_back(level);
      ones = tx_data[i] ? ones + 1 : 0;
      if (ones == 6) begin
        level = ~level;
        lv.push_back(level);
        ones = 0;
      end
    end
    enable = 1'b1;
    foreach (lv[i]) drive_line(lv[i], ~lv[i], alt_period ? ((i % 2 == 0) ? 9 : 7) : 8);
    if (with_eop) begin
      drive_line(1'b0, 1'b0, 16);
      drive_line(1'b1, 1'b0, 8);
    end
    enable = 1'b0;
    drive_line(1'b1, 1'b0, 4);
  endtask

  task automatic test_reset();
    n_rst        = 1'b0;
    d_plus_sync  = 1'b0;
    d_minus_sync = 1'b0;
    #1;
    checks++;
    if (d_edge !== 1'b1) begin errors++; $display("[TB] FAIL reset_d_edge_low_dp got %b want 1", d_edge); end
    checks++;
    if (bit_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_strobe got %b want 0", bit_strobe); end
    checks++;
    if (bit_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_out got %b want 0", bit_out); end
    checks++;
    if ({eop, stuff_err, line_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses got %b want 000", {eop, stuff_err, line_err}); end
    d_plus_sync = 1'b1;
    #1;
    checks++;
    if (d_edge !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_edge_j got %b want 0", d_edge); end
    step(3);
  endtask

  // Leave reset on an idle J with enable high: six 1s, a stuff error, one more 1.
  task automatic test_stuff_error();
    int k;
    enable       = 1'b1;
    d_plus_sync  = 1'b1;
    d_minus_sync = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    n_rst = 1'b1;
    k = cyc;
    step(64);
    enable = 1'b0;
    step(4);
    checks++;
    if (strb_bits.size() != 7) begin errors++; $display("[TB] FAIL stuff_err_strobe_count got %0d want 7", strb_bits.size()); end
    for (int i = 0; i < strb_bits.size() && i < 7; i++) begin
      checks++;
      if (strb_bits[i] !== 1'b1 || strb_cyc[i] != k + 4 + 8 * ((i < 6) ? i : 7)) begin
        errors++;
        $display("[TB] FAIL stuff_err_strobe%0d got bit %b cyc %0d want bit 1 cyc %0d", i, strb_bits[i], strb_cyc[i] - k, 4 + 8 * ((i < 6) ? i : 7));
      end
    end
    checks++;
    if (stuff_cyc.size() != 1 || (stuff_cyc.size() == 1 && stuff_cyc[0] != k + 52)) begin
      errors++;
      $display("[TB] FAIL stuff_err_pulse got count %0d want 1 at rel cyc 52", stuff_cyc.size());
    end
  endtask

  // K J K J with aligned edges: four 0s, each five cycles after its edge.
  task automatic test_nrzi_zeros();
    int k;
    clear_mon();
    enable = 1'b1;
    k = cyc;
    drive_line(1'b0, 1'b1, 8);
    drive_line(1'b1, 1'b0, 8);
    drive_line(1'b0, 1'b1, 8);
    drive_line(1'b1, 1'b0, 8);
    enable = 1'b0;
    drive_line(1'b1, 1'b0, 4);
    checks++;
    if (strb_bits.size() != 4) begin errors++; $display("[TB] FAIL zeros_count got %0d want 4", strb_bits.size()); end
    for (int i = 0; i < strb_bits.size() && i < 4; i++) begin
      checks++;
      if (strb_bits[i] !== 1'b0 || strb_cyc[i] != k + 5 + 8 * i) begin
        errors++;
        $display("[TB] FAIL zeros_strobe%0d got bit %b rel cyc %0d want bit 0 rel cyc %0d", i, strb_bits[i], strb_cyc[i] - k, 5 + 8 * i);
      end
    end
  endtask

  // Seven 1s: the transmitter inserts a stuffed 0 that must vanish.
  task automatic test_stuffed_bit();
    clear_mon();
    tx_data.delete();
    repeat (7) tx_data.push_back(1'b1);
    send_packet(1'b0, 1'b0);
    checks++;
    if (strb_bits.size() != 7) begin errors++; $display("[TB] FAIL stuffed_count got %0d want 7", strb_bits.size()); end
    foreach (strb_bits[i]) begin
      checks++;
      if (strb_bits[i] !== 1'b1) begin errors++; $display("[TB] FAIL stuffed_bit%0d got %b want 1", i, strb_bits[i]); end
    end
    checks++;
    if (stuff_cyc.size() != 0) begin errors++; $display("[TB] FAIL stuffed_no_err got %0d want 0", stuff_cyc.size()); end
  endtask

  // 16 random bits with periods alternating 9 and 7 clocks.
  task automatic test_period_jitter();
    clear_mon();
    tx_data.delete();
    repeat (16) tx_data.push_back(1'($urandom_range(0, 1)));
    send_packet(1'b1, 1'b0);
    checks++;
    if (strb_bits.size() != tx_data.size()) begin errors++; $display("[TB] FAIL jitter_count got %0d want %0d", strb_bits.size(), tx_data.size()); end
    for (int i = 0; i < strb_bits.size() && i < tx_data.size(); i++) begin
      checks++;
      if (strb_bits[i] !== tx_data[i]) begin errors++; $display("[TB] FAIL jitter_bit%0d got %b want %b", i, strb_bits[i], tx_data[i]); end
    end
    checks++;
    if (stuff_cyc.size() + lerr_cyc.size() != 0) begin errors++; $display("[TB] FAIL jitter_errors got %0d want 0", stuff_cyc.size() + lerr_cyc.size()); end
  endtask

  // Data 0,0,1 then SE0 for 16 clocks: one eop, then silence until re-enable.
  task automatic test_eop();
    int k;
    clear_mon();
    enable = 1'b1;
    k = cyc;
    drive_line(1'b0, 1'b1, 8);
    drive_line(1'b1, 1'b0, 8);
    drive_line(1'b1, 1'b0, 8);
    drive_line(1'b0, 1'b0, 16);
    drive_line(1'b1, 1'b0, 24);
    checks++;
    if (strb_bits.size() != 3) begin errors++; $display("[TB] FAIL eop_data_count got %0d want 3", strb_bits.size()); end
    else begin
      checks++;
      if ({strb_bits[0], strb_bits[1], strb_bits[2]} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL eop_data_bits got %b%b%b want 001", strb_bits[0], strb_bits[1], strb_bits[2]);
      end
    end
    checks++;
    if (eop_cyc.size() != 1 || (eop_cyc.size() == 1 && eop_cyc[0] != k + 37)) begin
      errors++;
      $display("[TB] FAIL eop_pulse got count %0d want 1 at rel cyc 37", eop_cyc.size());
    end
    checks++;
    if (lerr_cyc.size() != 0) begin errors++; $display("[TB] FAIL eop_line_err got %0d want 0", lerr_cyc.size()); end
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    drive_line(1'b0, 1'b1, 8);
    enable = 1'b0;
    drive_line(1'b1, 1'b0, 4);
    checks++;
    if (strb_bits.size() != 4 || strb_bits[strb_bits.size() - 1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL eop_reenable got count %0d want 4 ending in 0", strb_bits.size());
    end
  endtask

  // J K J SE1 K: the SE1 period raises line_err and produces no bit.
  task automatic test_line_err();
    int k;
    clear_mon();
    enable = 1'b1;
    k = cyc;
    drive_line(1'b1, 1'b0, 8);
    drive_line(1'b0, 1'b1, 8);
    drive_line(1'b1, 1'b0, 8);
    drive_line(1'b1, 1'b1, 8);
    drive_line(1'b0, 1'b1, 8);
    enable = 1'b0;
    drive_line(1'b1, 1'b0, 4);
    checks++;
    if (strb_bits.size() != 4) begin errors++; $display("[TB] FAIL se1_count got %0d want 4", strb_bits.size()); end
    else begin
      checks++;
      if ({strb_bits[0], strb_bits[1], strb_bits[2], strb_bits[3]} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL se1_bits got %b%b%b%b want 1000", strb_bits[0], strb_bits[1], strb_bits[2], strb_bits[3]);
      end
    end
    checks++;
    if (lerr_cyc.size() != 1 || (lerr_cyc.size() == 1 && lerr_cyc[0] != k + 29)) begin
      errors++;
      $display("[TB] FAIL se1_line_err got count %0d want 1 at rel cyc 29", lerr_cyc.size());
    end
  endtask

  // Reset while a strobe is high, then decode a fresh packet from J.
  task automatic test_reset_mid_packet();
    clear_mon();
    enable = 1'b1;
    drive_line(1'b1, 1'b0, 4);
    checks++;
    if (bit_strobe !== 1'b1 || bit_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre_strobe got %b/%b want 1/1", bit_strobe, bit_out);
    end
    d_plus_sync  = 1'b0;
    d_minus_sync = 1'b1;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bit_strobe, bit_out, eop, stuff_err, line_err} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got %b want 00000", {bit_strobe, bit_out, eop, stuff_err, line_err});
    end
    checks++;
    if (d_edge !== 1'b1) begin errors++; $display("[TB] FAIL midrst_d_edge got %b want 1", d_edge); end
    enable = 1'b0;
    step(2);
    drive_line(1'b1, 1'b0, 2);
    n_rst = 1'b1;
    step(2);
    clear_mon();
    tx_data.delete();
    repeat (12) tx_data.push_back(1'($urandom_range(0, 1)));
    send_packet(1'b0, 1'b1);
    checks++;
    if (strb_bits.size() != tx_data.size()) begin errors++; $display("[TB] FAIL midrst_count got %0d want %0d", strb_bits.size(), tx_data.size()); end
    for (int i = 0; i < strb_bits.size() && i < tx_data.size(); i++) begin
      checks++;
      if (strb_bits[i] !== tx_data[i]) begin errors++; $display("[TB] FAIL midrst_bit%0d got %b want %b", i, strb_bits[i], tx_data[i]); end
    end
    checks++;
    if (eop_cyc.size() != 1) begin errors++; $display("[TB] FAIL midrst_eop got %0d want 1", eop_cyc.size()); end
  endtask

  // Random packets, 1-heavy so stuffing is exercised, each closed with EOP.
  task automatic test_random_packets();
    for (int p = 0; p < 8; p++) begin
      clear_mon();
      tx_data.delete();
      repeat ($urandom_range(8, 24)) tx_data.push_back($urandom_range(0, 3) != 0);
      send_packet(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (strb_bits.size() != tx_data.size()) begin errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", p, strb_bits.size(), tx_data.size()); end
      for (int i = 0; i < strb_bits.size() && i < tx_data.size(); i++) begin
        checks++;
        if (strb_bits[i] !== tx_data[i]) begin errors++; $display("[TB] FAIL rand%0d_bit%0d got %b want %b", p, i, strb_bits[i], tx_data[i]); end
      end
      checks++;
      if (eop_cyc.size() != 1) begin errors++; $display("[TB] FAIL rand%0d_eop got %0d want 1", p, eop_cyc.size()); end
      checks++;
      if (stuff_cyc.size() + lerr_cyc.size() != 0) begin errors++; $display("[TB] FAIL rand%0d_errors got %0d want 0", p, stuff_cyc.size() + lerr_cyc.size()); end
    end
  endtask

  initial begin
    n_rst        = 1'b1;
    enable       = 1'b0;
    d_plus_sync  = 1'b1;
    d_minus_sync = 1'b0;
    #2;
    test_reset();
    test_stuff_error();
    test_nrzi_zeros();
    test_stuffed_bit();
    test_period_jitter();
    test_eop();
    test_line_err();
    test_reset_mid_packet();
    test_random_packets();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
